// File: rtl/cc_screen_sequencer.sv
// Game-flow FSM selecting COMIENZO/RANDOM/TRANSI/PIERDO screens; tracks the current level.
// Latency: an event present at clock edge N moves the state; select/load/level follow on edge N+1.
// No backpressure: event inputs are single-cycle pulses, consumed or ignored in the cycle they appear.
module cc_screen_sequencer #(
    parameter int SEQ_SELECTWIDTH  = 4,
    parameter int SEQ_TRANSI_TICKS = 4,
    parameter int SEQ_PIERDO_TICKS = 8,
    parameter int SEQ_TICKCNTWIDTH = 8,
    parameter int SEQ_LEVELWIDTH   = 4
) (
    input  logic                       CC_SEQ_CLOCK_50,
    input  logic                       CC_SEQ_RESET_InHigh,
    input  logic                       CC_SEQ_start_In,
    input  logic                       CC_SEQ_tick_In,
    input  logic                       CC_SEQ_collision_In,
    input  logic                       CC_SEQ_levelUp_In,
    output logic [SEQ_SELECTWIDTH-1:0] CC_SEQ_select_OutBUS,
    output logic                       CC_SEQ_load_Out,
    output logic [SEQ_LEVELWIDTH-1:0]  CC_SEQ_level_OutBUS
);

    // State codes double as the mux select value.
    localparam logic [1:0] ST_COMIENZO = 2'd0;
    localparam logic [1:0] ST_RANDOM   = 2'd1;
    localparam logic [1:0] ST_TRANSI   = 2'd2;
    localparam logic [1:0] ST_PIERDO   = 2'd3;

    localparam logic [SEQ_TICKCNTWIDTH-1:0] TRANSI_LAST = SEQ_TICKCNTWIDTH'(SEQ_TRANSI_TICKS - 1);
    localparam logic [SEQ_TICKCNTWIDTH-1:0] PIERDO_LAST = SEQ_TICKCNTWIDTH'(SEQ_PIERDO_TICKS - 1);
    localparam logic [SEQ_LEVELWIDTH-1:0]   LEVEL_MAX   = '1;

    logic [1:0]                  state_q,      state_d;
    logic [SEQ_TICKCNTWIDTH-1:0] tick_cnt_q,   tick_cnt_d;
    logic [SEQ_LEVELWIDTH-1:0]   level_q,      level_d;
    logic                        start_prev_q, start_prev_d;
    logic [SEQ_SELECTWIDTH-1:0]  select_q,     select_d;
    logic                        load_q,       load_d;
    logic [SEQ_LEVELWIDTH-1:0]   level_out_q,  level_out_d;
    logic                        start_rise;

    // start_prev resets high so a button held through reset release is not seen as a press.
    assign start_rise = CC_SEQ_start_In & ~start_prev_q;

    // State register: FSM state, tick counter, level and start edge detector.
    always_ff @(posedge CC_SEQ_CLOCK_50 or posedge CC_SEQ_RESET_InHigh) begin
        if (CC_SEQ_RESET_InHigh) begin
            state_q      <= ST_COMIENZO;
            tick_cnt_q   <= '0;
            level_q      <= '0;
            start_prev_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            level_q      <= level_d;
            start_prev_q <= start_prev_d;
        end
    end

    // Next-state logic; the tick counter clears on every transition so a tick on the entry edge is not counted.
    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        level_d      = level_q;
        start_prev_d = CC_SEQ_start_In;
        case (state_q)
            ST_COMIENZO: begin
                if (start_rise) begin
                    state_d    = ST_RANDOM;
                    level_d    = SEQ_LEVELWIDTH'(1);
                    tick_cnt_d = '0;
                end
            end
            ST_RANDOM: begin
                // Collision takes priority over a simultaneous level-up.
                if (CC_SEQ_collision_In) begin
                    state_d    = ST_PIERDO;
                    tick_cnt_d = '0;
                end else if (CC_SEQ_levelUp_In) begin
                    state_d    = ST_TRANSI;
                    tick_cnt_d = '0;
                end
            end
            ST_TRANSI: begin
                if (CC_SEQ_tick_In) begin
                    if (tick_cnt_q == TRANSI_LAST) begin
                        state_d    = ST_RANDOM;
                        tick_cnt_d = '0;
                        level_d    = (level_q == LEVEL_MAX) ? level_q : level_q + 1'b1;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                if (CC_SEQ_tick_In) begin
                    if (tick_cnt_q == PIERDO_LAST) begin
                        state_d    = ST_COMIENZO;
                        tick_cnt_d = '0;
                        level_d    = '0;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
        endcase
    end

    // Output decode: select mirrors the state code, load flags any change of select.
    always_comb begin
        select_d    = SEQ_SELECTWIDTH'(state_q);
        load_d      = (select_d != select_q);
        level_out_d = level_q;
    end

    // Output register: every output leaves the block from a flop.
    always_ff @(posedge CC_SEQ_CLOCK_50 or posedge CC_SEQ_RESET_InHigh) begin
        if (CC_SEQ_RESET_InHigh) begin
            select_q    <= '0;
            load_q      <= 1'b0;
            level_out_q <= '0;
        end else begin
            select_q    <= select_d;
            load_q      <= load_d;
            level_out_q <= level_out_d;
        end
    end

    assign CC_SEQ_select_OutBUS = select_q;
    assign CC_SEQ_load_Out      = load_q;
    assign CC_SEQ_level_OutBUS  = level_out_q;

endmodule

// File: tb/tb_cc_screen_sequencer.sv
// Directed bench for cc_screen_sequencer: vector table plus hand sequences for saturation and mid-run reset.
// Outputs are compared 1 time unit after each rising edge; inputs change at the same point.
// A second instance with a 2-bit level counter shares the stimulus for the saturation sequence.
module tb_cc_screen_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_in, tick_in, coll_in, lvlup_in;
    logic [3:0] sel;
    logic       load;
    logic [3:0] level;
    logic [3:0] sel2;
    logic       load2;
    logic [1:0] level2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cc_screen_sequencer dut (
        .CC_SEQ_CLOCK_50      (clk),
        .CC_SEQ_RESET_InHigh  (rst),
        .CC_SEQ_start_In      (start_in),
        .CC_SEQ_tick_In       (tick_in),
        .CC_SEQ_collision_In  (coll_in),
        .CC_SEQ_levelUp_In    (lvlup_in),
        .CC_SEQ_select_OutBUS (sel),
        .CC_SEQ_load_Out      (load),
        .CC_SEQ_level_OutBUS  (level)
    );

    cc_screen_sequencer #(.SEQ_LEVELWIDTH(2)) dut2 (
        .CC_SEQ_CLOCK_50      (clk),
        .CC_SEQ_RESET_InHigh  (rst),
        .CC_SEQ_start_In      (start_in),
        .CC_SEQ_tick_In       (tick_in),
        .CC_SEQ_collision_In  (coll_in),
        .CC_SEQ_levelUp_In    (lvlup_in),
        .CC_SEQ_select_OutBUS (sel2),
        .CC_SEQ_load_Out      (load2),
        .CC_SEQ_level_OutBUS  (level2)
    );

    typedef struct {
        logic       start;
        logic       tick;
        logic       coll;
        logic       lvlup;
        logic [3:0] exp_sel;
        logic       exp_load;
        logic [3:0] exp_level;
    } vec_t;

    localparam int NVEC = 25;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, let one rising edge sample them, then settle.
    task automatic cyc(input logic s, input logic t, input logic c, input logic l);
        start_in = s;
        tick_in  = t;
        coll_in  = c;
        lvlup_in = l;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Expected outputs of a row are those seen after the edge that samples that row's inputs;
        // they reflect the state reached one edge earlier.
        //             st tk co lu  sel load lvl
        vecs[0]  = '{1, 0, 0, 0,  0, 0, 0};   // start held from reset: no press
        vecs[1]  = '{0, 0, 0, 0,  0, 0, 0};
        vecs[2]  = '{1, 0, 0, 0,  0, 0, 0};   // rising edge -> RANDOM
        vecs[3]  = '{1, 0, 0, 0,  1, 1, 1};
        vecs[4]  = '{0, 0, 0, 0,  1, 0, 1};
        vecs[5]  = '{0, 1, 0, 1,  1, 0, 1};   // levelUp -> TRANSI, entry tick not counted
        vecs[6]  = '{0, 1, 0, 0,  2, 1, 1};   // tick 1
        vecs[7]  = '{0, 1, 0, 0,  2, 0, 1};   // tick 2
        vecs[8]  = '{0, 0, 0, 0,  2, 0, 1};
        vecs[9]  = '{0, 1, 0, 0,  2, 0, 1};   // tick 3
        vecs[10] = '{0, 1, 1, 0,  2, 0, 1};   // tick 4 -> RANDOM, collision ignored in TRANSI
        vecs[11] = '{0, 0, 0, 0,  1, 1, 2};
        vecs[12] = '{0, 0, 1, 1,  1, 0, 2};   // collision beats levelUp -> PIERDO
        vecs[13] = '{1, 0, 0, 0,  3, 1, 2};   // start press ignored in PIERDO
        vecs[14] = '{0, 1, 0, 0,  3, 0, 2};   // PIERDO tick 1
        vecs[15] = '{1, 1, 0, 0,  3, 0, 2};   // tick 2
        vecs[16] = '{0, 1, 0, 0,  3, 0, 2};   // tick 3
        vecs[17] = '{0, 1, 0, 0,  3, 0, 2};   // tick 4
        vecs[18] = '{0, 1, 0, 0,  3, 0, 2};   // tick 5
        vecs[19] = '{1, 1, 0, 0,  3, 0, 2};   // tick 6
        vecs[20] = '{0, 1, 0, 0,  3, 0, 2};   // tick 7
        vecs[21] = '{0, 1, 0, 0,  3, 0, 2};   // tick 8 -> COMIENZO
        vecs[22] = '{0, 0, 0, 0,  0, 1, 0};
        vecs[23] = '{0, 1, 1, 1,  0, 0, 0};   // events ignored on start screen
        vecs[24] = '{0, 0, 0, 0,  0, 0, 0};

        rst      = 1'b1;
        start_in = 1'b1;
        tick_in  = 1'b0;
        coll_in  = 1'b0;
        lvlup_in = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_sel", int'(sel), 0);
        chk("reset_load", int'(load), 0);
        chk("reset_level", int'(level), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            cyc(vecs[i].start, vecs[i].tick, vecs[i].coll, vecs[i].lvlup);
            chk($sformatf("vec%0d_sel", i), int'(sel), int'(vecs[i].exp_sel));
            chk($sformatf("vec%0d_load", i), int'(load), int'(vecs[i].exp_load));
            chk($sformatf("vec%0d_level", i), int'(level), int'(vecs[i].exp_level));
        end

        // Level saturation: 2-bit instance stops at 3 while the 4-bit one keeps counting.
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("sat_start_sel", int'(sel2), 1);
        chk("sat_start_level2", int'(level2), 1);
        for (int k = 0; k < 5; k++) begin
            cyc(0, 0, 0, 1);
            for (int t = 0; t < 4; t++) cyc(0, 1, 0, 0);
            cyc(0, 0, 0, 0);
            chk($sformatf("sat%0d_sel", k), int'(sel2), 1);
            chk($sformatf("sat%0d_load", k), int'(load2), 1);
            chk($sformatf("sat%0d_level2", k), int'(level2), (k + 2 > 3) ? 3 : k + 2);
            chk($sformatf("sat%0d_level4", k), int'(level), k + 2);
        end

        // Asynchronous reset in TRANSI with the tick counter at 2.
        cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        chk("pre_rst_sel", int'(sel), 2);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_sel", int'(sel), 0);
        chk("async_rst_load", int'(load), 0);
        chk("async_rst_level", int'(level), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int j = 0; j < 3; j++) begin
            cyc(0, 1, 0, 0);
            chk($sformatf("post_rst%0d_sel", j), int'(sel), 0);
            chk($sformatf("post_rst%0d_load", j), int'(load), 0);
            chk($sformatf("post_rst%0d_level", j), int'(level), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
